// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one miso UART transmitter between the local event FIFO
// and the pass-through stream from the downstream chain.
//
// Ports
//   clk2x        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   arb_enable   permits new grants
//   local_valid  local packet available; local_data is the packet
//   local_ack    one-cycle pulse, local packet consumed (same cycle as tx_load)
//   pass_valid   pass-through packet available; pass_data is the packet
//   pass_ack     one-cycle pulse, pass packet consumed (same cycle as tx_load)
//   tx_busy      transmitter busy
//   tx_load      one-cycle pulse, tx_data valid for the transmitter
//   tx_data      registered packet, held between grants
//   grant_src    source of the last grant: 0 = local, 1 = pass
//   tx_err       sticky transmitter-timeout flag, cleared only by reset
//
// state     | meaning
// IDLE      | waiting for a request; grants are issued only from here
// WAIT_BUSY | load issued, waiting up to TIMEOUT cycles for tx_busy to rise
// WAIT_DONE | transmitter busy, waiting for it to finish
module tx_arbiter #(
  parameter int WIDTH      = 54,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk2x,
  input  logic             reset_n,
  input  logic             arb_enable,
  input  logic             local_valid,
  input  logic [WIDTH-1:0] local_data,
  output logic             local_ack,
  input  logic             pass_valid,
  input  logic [WIDTH-1:0] pass_data,
  output logic             pass_ack,
  input  logic             tx_busy,
  output logic             tx_load,
  output logic [WIDTH-1:0] tx_data,
  output logic             grant_src,
  output logic             tx_err
);

  localparam int CW = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    consec_q;
  logic [TW-1:0]    tmr_q;
  logic             tx_load_q;
  logic             local_ack_q;
  logic             pass_ack_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             grant_src_q;
  logic             tx_err_q;

  logic             grant_ok;
  logic             sel_local;
  logic [CW-1:0]    consec_d;

  // Pass has priority unless local has already waited through MAX_CONSEC
  // pass grants.
  always_comb begin
    grant_ok  = arb_enable && !tx_busy && (local_valid || pass_valid);
    sel_local = local_valid && (!pass_valid || (consec_q == CONSEC_MAX));
    consec_d  = '0;
    if (!sel_local && local_valid) begin
      consec_d = (consec_q < CONSEC_MAX) ? consec_q + CW'(1) : consec_q;
    end
  end

  always_ff @(posedge clk2x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      consec_q    <= '0;
      tmr_q       <= '0;
      tx_load_q   <= 1'b0;
      local_ack_q <= 1'b0;
      pass_ack_q  <= 1'b0;
      tx_data_q   <= '0;
      grant_src_q <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      tx_load_q   <= 1'b0;
      local_ack_q <= 1'b0;
      pass_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            tx_load_q   <= 1'b1;
            local_ack_q <= sel_local;
            pass_ack_q  <= !sel_local;
            tx_data_q   <= sel_local ? local_data : pass_data;
            grant_src_q <= !sel_local;
            consec_q    <= consec_d;
            tmr_q       <= TMR_LOAD;
            state_q     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmr_q == '0) begin
            tx_err_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_load   = tx_load_q;
  assign local_ack = local_ack_q;
  assign pass_ack  = pass_ack_q;
  assign tx_data   = tx_data_q;
  assign grant_src = grant_src_q;
  assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;
  localparam int WIDTH = 54;
  localparam logic [WIDTH-1:0] LDATA = 54'h2A_5555_AAAA_5555;
  localparam logic [WIDTH-1:0] PDATA = 54'h15_A5A5_0F0F_3C3C;

  logic             clk2x = 1'b0;
  logic             reset_n = 1'b0;
  logic             arb_enable = 1'b0;
  logic             local_valid = 1'b0;
  logic [WIDTH-1:0] local_data = '0;
  logic             local_ack;
  logic             pass_valid = 1'b0;
  logic [WIDTH-1:0] pass_data = '0;
  logic             pass_ack;
  logic             tx_busy = 1'b0;
  logic             tx_load;
  logic [WIDTH-1:0] tx_data;
  logic             grant_src;
  logic             tx_err;

  int tests = 0;
  int fails = 0;

  logic [WIDTH:0] exp_q[$];
  logic           model_en = 1'b0;
  int             busy_len = 3;
  logic           prev_load = 1'b0;

  tx_arbiter #(.WIDTH(WIDTH), .MAX_CONSEC(4), .TIMEOUT(8)) dut (
    .clk2x(clk2x), .reset_n(reset_n), .arb_enable(arb_enable),
    .local_valid(local_valid), .local_data(local_data), .local_ack(local_ack),
    .pass_valid(pass_valid), .pass_data(pass_data), .pass_ack(pass_ack),
    .tx_busy(tx_busy), .tx_load(tx_load), .tx_data(tx_data),
    .grant_src(grant_src), .tx_err(tx_err)
  );

  always #5 clk2x = ~clk2x;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk2x);
      if (tx_load === 1'b1) got = 1'b1;
    end
    check(tag, {63'd0, got}, 64'd1);
  endtask

  task automatic push(input logic src);
    exp_q.push_back({src, src ? PDATA : LDATA});
  endtask

  task automatic apply_reset();
    @(negedge clk2x);
    reset_n     = 1'b0;
    local_valid = 1'b0;
    pass_valid  = 1'b0;
    arb_enable  = 1'b1;
    repeat (2) @(negedge clk2x);
    check("rst_outputs", {tx_load, local_ack, pass_ack, grant_src, tx_err}, 64'd0);
    check("rst_tx_data", {10'd0, tx_data}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk2x);
  endtask

  // Transmitter model: busy for busy_len cycles after each observed load.
  initial begin
    forever begin
      @(negedge clk2x);
      if (model_en && tx_load === 1'b1) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk2x);
        tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every load pops one expected grant.
  always @(negedge clk2x) begin
    if (tx_load === 1'b1) begin
      check("load_gap", {63'd0, prev_load}, 64'd0);
      check("ack_match", {62'd0, local_ack, pass_ack}, grant_src ? 64'd1 : 64'd2);
      check("queue_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) check("grant", {9'd0, grant_src, tx_data}, {9'd0, exp_q.pop_front()});
    end else if ((local_ack | pass_ack) !== 1'b0) begin
      check("stray_ack", {62'd0, local_ack, pass_ack}, 64'd0);
    end
    prev_load = tx_load;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int loads;
    local_data = LDATA;
    pass_data  = PDATA;

    // Single local packet: latency, outputs, hold afterwards.
    apply_reset();
    model_en = 1'b1; busy_len = 3;
    local_valid = 1'b1; push(1'b0);
    @(negedge clk2x);
    check("local_latency", {61'd0, tx_load, local_ack, pass_ack}, 64'h6);
    check("local_src", {63'd0, grant_src}, 64'd0);
    check("local_data", {10'd0, tx_data}, {10'd0, LDATA});
    local_valid = 1'b0;
    repeat (8) @(negedge clk2x);
    check("hold_data", {9'd0, grant_src, tx_data}, {10'd0, LDATA});
    check("no_err", {63'd0, tx_err}, 64'd0);

    // Arbitration disabled blocks grants; enabling grants pass next cycle.
    apply_reset();
    arb_enable = 1'b0; local_valid = 1'b1; pass_valid = 1'b1;
    loads = 0;
    repeat (20) begin
      @(negedge clk2x);
      if (tx_load === 1'b1) loads++;
    end
    check("disabled_loads", 64'(loads), 64'd0);
    arb_enable = 1'b1; push(1'b1);
    @(negedge clk2x);
    check("enable_grant", {62'd0, tx_load, grant_src}, 64'd3);
    local_valid = 1'b0; pass_valid = 1'b0;
    repeat (10) @(negedge clk2x);

    // Both valid, busy 5 cycles: P,P,P,P,L,P,P,P,P,L.
    apply_reset();
    busy_len = 5;
    for (int i = 0; i < 10; i++) push((i % 5) != 4);
    local_valid = 1'b1; pass_valid = 1'b1;
    for (int i = 0; i < 10; i++) wait_load("fair_load", 30);
    local_valid = 1'b0; pass_valid = 1'b0;
    repeat (10) @(negedge clk2x);
    check("fair_queue_empty", 64'(exp_q.size()), 64'd0);

    // Transmitter never goes busy: timeout after 8 WAIT_BUSY cycles.
    apply_reset();
    model_en = 1'b0;
    local_valid = 1'b1; push(1'b0);
    @(negedge clk2x);
    check("to_load", {63'd0, tx_load}, 64'd1);
    local_valid = 1'b0;
    repeat (7) @(negedge clk2x);
    check("to_err_early", {63'd0, tx_err}, 64'd0);
    @(negedge clk2x);
    check("to_err_set", {63'd0, tx_err}, 64'd1);
    model_en = 1'b1; busy_len = 2;
    pass_valid = 1'b1; push(1'b1);
    @(negedge clk2x);
    check("to_next_grant", {63'd0, tx_load}, 64'd1);
    pass_valid = 1'b0;
    repeat (10) @(negedge clk2x);
    check("to_err_sticky", {63'd0, tx_err}, 64'd1);

    // Ten pass-only packets, then local wins; counter restarts after it.
    apply_reset();
    busy_len = 2;
    for (int i = 0; i < 10; i++) push(1'b1);
    pass_valid = 1'b1;
    for (int i = 0; i < 10; i++) wait_load("pass_only_load", 20);
    pass_valid = 1'b0; local_valid = 1'b1; push(1'b0);
    wait_load("local_after_pass", 20);
    pass_valid = 1'b1;
    for (int i = 0; i < 5; i++) push(i != 4);
    for (int i = 0; i < 5; i++) wait_load("refair_load", 20);
    pass_valid = 1'b0; local_valid = 1'b0;
    repeat (10) @(negedge clk2x);
    check("pass_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-WAIT_DONE clears outputs at once; no ack after release.
    apply_reset();
    busy_len = 10;
    local_valid = 1'b1; push(1'b0);
    wait_load("mid_load", 5);
    local_valid = 1'b0;
    repeat (3) @(negedge clk2x);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {tx_load, local_ack, pass_ack, grant_src, tx_err}, 64'd0);
    check("mid_rst_data", {10'd0, tx_data}, 64'd0);
    repeat (2) @(negedge clk2x);
    reset_n = 1'b1;
    loads = 0;
    repeat (20) begin
      @(negedge clk2x);
      if ((tx_load | local_ack | pass_ack) === 1'b1) loads++;
    end
    check("post_rst_quiet", 64'(loads), 64'd0);
    busy_len = 2;
    pass_valid = 1'b1; push(1'b1);
    wait_load("post_rst_grant", 5);
    pass_valid = 1'b0;
    repeat (10) @(negedge clk2x);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
